pair_match_engine: RTL and testbench
====================================

Name: pair_match_engine

Overview:
Turn-sequencing stage for the tile-flip game. It sits between the debounced switch bank plus the shuffled tile array, and the VGA driver.
- Converts switch rising edges into tile picks.
- Enforces the two-picks-per-turn rule and compares the two picked tile values.
- Holds a mismatched pair visible for a fixed time, counts tries and flags the win.
- Drives the face_up, matched_tiles and mismatched_tiles masks consumed by vga_driver.

Parameters:
NUM_TILES, 16, number of tiles; one switch per tile.
VAL_W, 3, bits per tile value in the flat value bus.
REVEAL_CYCLES, 50000000, clk cycles a mismatched pair stays shown (1 s at 50 MHz); must be >=1.
TRIES_W, 8, width of the tries counter.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
new_game  in  1  pulse; restarts the game
switches  in  NUM_TILES  debounced switch levels
tile_values  in  NUM_TILES*VAL_W  flat value array; tile i at bits [i*VAL_W +: VAL_W]
values_valid  in  1  shuffled array stable/ready
face_up  out  NUM_TILES  revealed, not-yet-matched tiles
matched_tiles  out  NUM_TILES  tiles already paired
mismatched_tiles  out  NUM_TILES  pair currently shown as wrong
tries  out  TRIES_W  completed turns
game_won  out  1  all tiles matched
busy  out  1  picks are currently ignored (IDLE, COMPARE, SHOW_MISMATCH, WON)

Behaviour:
Interface: reset reset, synchronous, active-high; clock clk.

Reset and priority:
- Reset clears all outputs to 0 and sets state to IDLE. busy=1 in IDLE.
- sw_prev loads the current switches at reset and at new_game. Switches already high therefore create no pick.
- Priority: reset > new_game > everything else. new_game performs the same clear as reset, in any state.

Pick detection:
- rise = switches & ~sw_prev, combinational. sw_prev <= switches every cycle.
- A pick is valid only if:
  - the state is PICK1 or PICK2;
  - the tile is not matched and not face_up.
- If several valid rises occur in one cycle, the lowest index wins. The others are dropped, not queued.
- Pick latency: face_up bit is set 1 cycle after the switch rises.

State machine:
- IDLE: on values_valid, snapshot tile_values into an internal register, then go to PICK1. Later changes to tile_values are ignored until the next new_game.
- PICK1: on a valid pick i: first_idx<=i, set face_up[i], go to PICK2.
- PICK2: on a valid pick j: second_idx<=j, set face_up[j], go to COMPARE. Because first_idx is face_up, j != first_idx is guaranteed.
- COMPARE (exactly 1 cycle): tries <= tries+1, saturating at 2^TRIES_W-1.
  - Values equal: set both bits in matched_tiles and clear them in face_up. If matched_tiles becomes all ones, go to WON; otherwise go to PICK1.
  - Values differ: set both bits in mismatched_tiles, load timer with REVEAL_CYCLES-1, go to SHOW_MISMATCH.
- SHOW_MISMATCH: timer decrements each cycle and picks are ignored. At timer==0, clear face_up and mismatched_tiles, go to PICK1. mismatched_tiles is high for exactly REVEAL_CYCLES cycles.
- WON: game_won=1 and all outputs hold until new_game or reset.

Timing and invariants:
- matched_tiles updates 2 cycles after the second switch rises.
- face_up, matched_tiles and mismatched_tiles are all registered outputs.
- matched_tiles & face_up == 0 at all times.

Optional Feature:
Macro: PICK_CANCEL_EN.
- Defined: in PICK2, a falling edge on switches[first_idx] clears face_up[first_idx] and returns to PICK1. tries is not incremented.
  - If a valid rise occurs in the same cycle, the cancel wins and the rise is dropped.
- Undefined: falling edges are ignored in every state.

Test Plan:
All scenarios: REVEAL_CYCLES=4, tile i value = i>>1, values_valid=1.
1. Reset; raise sw0, then 3 cycles later raise sw1 -> face_up=0x0001, then matched_tiles=0x0003, face_up=0, tries=1, busy=0.
2. Raise sw0, then sw2 -> mismatched_tiles=0x0005 for exactly 4 cycles, then face_up=0, mismatched_tiles=0, tries=1, back in PICK1.
3. In PICK1, raise sw5 and sw3 in the same cycle -> face_up=0x0008 only. Next, raise sw2 -> match, matched_tiles=0x000C.
4. After tiles 0/1 are matched, lower and re-raise sw0 -> ignored, face_up unchanged, tries unchanged. With PICK_CANCEL_EN: pick sw4, then lower sw4 -> face_up=0, tries unchanged.
5. Match all 8 pairs in order -> matched_tiles=0xFFFF, game_won=1, tries=8. Pulse new_game -> all outputs 0, game_won=0. Next cycle state is PICK1.
6. Hold sw7 high through reset -> no pick. Assert reset during SHOW_MISMATCH -> next cycle all outputs 0 and the timer is abandoned.

Source files
------------

// File: rtl/pair_match_engine.sv
// pair_match_engine: turn sequencing for the tile-flip game.
// Turns switch rising edges into tile picks, compares each pair of picks,
// holds a mismatched pair on screen for REVEAL_CYCLES, counts tries, flags the win.
// Optional feature macro: PICK_CANCEL_EN (falling edge on the first pick's
// switch while waiting for the second pick withdraws the first pick).
module pair_match_engine #(
   parameter int NUM_TILES     = 16,
   parameter int VAL_W         = 3,
   parameter int REVEAL_CYCLES = 50000000,
   parameter int TRIES_W       = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       new_game,
   input  logic [NUM_TILES-1:0]       switches,
   input  logic [NUM_TILES*VAL_W-1:0] tile_values,
   input  logic                       values_valid,
   output logic [NUM_TILES-1:0]       face_up,
   output logic [NUM_TILES-1:0]       matched_tiles,
   output logic [NUM_TILES-1:0]       mismatched_tiles,
   output logic [TRIES_W-1:0]         tries,
   output logic                       game_won,
   output logic                       busy
);

   localparam int IDX_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
   localparam int TIMER_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      PICK1,
      PICK2,
      COMPARE,
      SHOW_MISMATCH,
      WON
   } state_t;

   state_t               state_q, state_n;
   logic [NUM_TILES-1:0] face_up_q, face_up_n;
   logic [NUM_TILES-1:0] matched_q, matched_n;
   logic [NUM_TILES-1:0] mism_q, mism_n;
   logic [TRIES_W-1:0]   tries_q, tries_n;
   logic [TIMER_W-1:0]   timer_q, timer_n;
   logic [IDX_W-1:0]     first_q, first_n;
   logic [IDX_W-1:0]     second_q, second_n;
   logic [NUM_TILES-1:0] sw_prev;
   logic [VAL_W-1:0]     vals_q [NUM_TILES];

   logic [NUM_TILES-1:0] rise;
   logic [NUM_TILES-1:0] cand;
   logic [NUM_TILES-1:0] pair_mask;
   logic                 pick_any;
   logic [IDX_W-1:0]     pick_idx;
   logic                 cancel;
   logic                 load_vals;

   // Next-state and datapath updates; new_game overrides everything below it
   always_comb begin
      rise     = switches & ~sw_prev;
      cand     = rise & ~matched_q & ~face_up_q;
      pick_any = 1'b0;
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_TILES; i++) begin
         if (cand[i] && !pick_any) begin
            pick_any = 1'b1;
            pick_idx = IDX_W'(i);
         end
      end

      pair_mask           = '0;
      pair_mask[first_q]  = 1'b1;
      pair_mask[second_q] = 1'b1;

`ifdef PICK_CANCEL_EN
      cancel = (state_q == PICK2) && sw_prev[first_q] && !switches[first_q];
`else
      cancel = 1'b0;
`endif

      state_n   = state_q;
      face_up_n = face_up_q;
      matched_n = matched_q;
      mism_n    = mism_q;
      tries_n   = tries_q;
      timer_n   = timer_q;
      first_n   = first_q;
      second_n  = second_q;
      load_vals = 1'b0;

      case (state_q)
         IDLE: begin
            if (values_valid) begin
               load_vals = 1'b1;
               state_n   = PICK1;
            end
         end
         PICK1: begin
            if (pick_any) begin
               first_n             = pick_idx;
               face_up_n[pick_idx] = 1'b1;
               state_n             = PICK2;
            end
         end
         PICK2: begin
            if (cancel) begin
               face_up_n[first_q] = 1'b0;
               state_n            = PICK1;
            end else if (pick_any) begin
               second_n            = pick_idx;
               face_up_n[pick_idx] = 1'b1;
               state_n             = COMPARE;
            end
         end
         COMPARE: begin
            if (tries_q != '1) tries_n = tries_q + TRIES_W'(1);
            if (vals_q[first_q] == vals_q[second_q]) begin
               matched_n = matched_q | pair_mask;
               face_up_n = face_up_q & ~pair_mask;
               state_n   = (&matched_n) ? WON : PICK1;
            end else begin
               mism_n  = mism_q | pair_mask;
               timer_n = TIMER_W'(REVEAL_CYCLES - 1);
               state_n = SHOW_MISMATCH;
            end
         end
         SHOW_MISMATCH: begin
            if (timer_q == '0) begin
               face_up_n = '0;
               mism_n    = '0;
               state_n   = PICK1;
            end else begin
               timer_n = timer_q - TIMER_W'(1);
            end
         end
         WON: ;
         default: state_n = IDLE;
      endcase

      if (new_game) begin
         state_n   = IDLE;
         face_up_n = '0;
         matched_n = '0;
         mism_n    = '0;
         tries_n   = '0;
         timer_n   = '0;
         first_n   = '0;
         second_n  = '0;
         load_vals = 1'b0;
      end
   end

   // State and output registers; sw_prev tracks switches every cycle, reset included
   always_ff @(posedge clk) begin
      sw_prev <= switches;
      if (reset) begin
         state_q   <= IDLE;
         face_up_q <= '0;
         matched_q <= '0;
         mism_q    <= '0;
         tries_q   <= '0;
         timer_q   <= '0;
         first_q   <= '0;
         second_q  <= '0;
      end else begin
         state_q   <= state_n;
         face_up_q <= face_up_n;
         matched_q <= matched_n;
         mism_q    <= mism_n;
         tries_q   <= tries_n;
         timer_q   <= timer_n;
         first_q   <= first_n;
         second_q  <= second_n;
      end
   end

   // Snapshot of the shuffled values, taken once when leaving IDLE
   always_ff @(posedge clk) begin
      if (!reset && load_vals) begin
         for (int unsigned i = 0; i < NUM_TILES; i++) begin
            vals_q[i] <= tile_values[i*VAL_W +: VAL_W];
         end
      end
   end

   assign face_up          = face_up_q;
   assign matched_tiles    = matched_q;
   assign mismatched_tiles = mism_q;
   assign tries            = tries_q;
   assign game_won         = (state_q == WON);
   assign busy             = (state_q != PICK1) && (state_q != PICK2);

endmodule

// File: tb/tb_pair_match_engine.sv
// Testbench for pair_match_engine: directed scenarios plus random play,
// every cycle compared against a pick/turn level reference model.
module tb_pair_match_engine;

   localparam int NT = 16;
   localparam int VW = 3;
   localparam int RC = 4;
   localparam int TW = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              new_game = 1'b0;
   logic [NT-1:0]     switches = '0;
   logic [NT*VW-1:0]  tile_values = '0;
   logic              values_valid = 1'b1;
   logic [NT-1:0]     face_up, matched_tiles, mismatched_tiles;
   logic [TW-1:0]     tries;
   logic              game_won, busy;

   int n_tests = 0;
   int n_fail  = 0;

   pair_match_engine #(.NUM_TILES(NT), .VAL_W(VW), .REVEAL_CYCLES(RC), .TRIES_W(TW)) dut (
      .clk(clk), .reset(reset), .new_game(new_game), .switches(switches),
      .tile_values(tile_values), .values_valid(values_valid), .face_up(face_up),
      .matched_tiles(matched_tiles), .mismatched_tiles(mismatched_tiles),
      .tries(tries), .game_won(game_won), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: tracks the game as "snapshot taken", picked tiles,
   // pending comparison and remaining display time.
   bit [NT-1:0] m_face, m_match, m_mism, m_prev;
   int          m_tries, m_show, m_first, m_second;
   bit          m_ready, m_cmp, m_won;
   int          m_vals [NT];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit [NT-1:0] rise, fall, pair;
      bit          cancelled;
      rise = switches & ~m_prev;
      fall = ~switches & m_prev;
      if (reset || new_game) begin
         m_face = '0; m_match = '0; m_mism = '0; m_tries = 0; m_show = 0;
         m_first = -1; m_second = -1; m_ready = 0; m_cmp = 0; m_won = 0;
      end else if (!m_ready) begin
         if (values_valid) begin
            for (int i = 0; i < NT; i++) m_vals[i] = int'(tile_values[i*VW +: VW]);
            m_ready = 1;
         end
      end else if (m_won) begin
      end else if (m_cmp) begin
         m_cmp = 0;
         if (m_tries < (1 << TW) - 1) m_tries++;
         pair = '0;
         pair[m_first] = 1'b1;
         pair[m_second] = 1'b1;
         if (m_vals[m_first] == m_vals[m_second]) begin
            m_match |= pair;
            m_face &= ~pair;
            if (m_match == '1) m_won = 1;
         end else begin
            m_mism |= pair;
            m_show = RC;
         end
         m_first = -1;
      end else if (m_show > 0) begin
         m_show--;
         if (m_show == 0) begin
            m_face = '0;
            m_mism = '0;
         end
      end else begin
         cancelled = 0;
`ifdef PICK_CANCEL_EN
         if (m_first >= 0 && fall[m_first]) begin
            m_face[m_first] = 1'b0;
            m_first = -1;
            cancelled = 1;
         end
`endif
         if (!cancelled) begin
            for (int i = 0; i < NT; i++) begin
               if (rise[i] && !m_match[i] && !m_face[i]) begin
                  m_face[i] = 1'b1;
                  if (m_first < 0) m_first = i;
                  else begin
                     m_second = i;
                     m_cmp = 1;
                  end
                  break;
               end
            end
         end
      end
      m_prev = switches;
   endtask

   task automatic tick();
      bit exp_busy;
      @(posedge clk);
      model_step();
      #1;
      exp_busy = !m_ready || m_won || m_cmp || (m_show > 0);
      check("face_up", face_up, m_face);
      check("matched", matched_tiles, m_match);
      check("mismatched", mismatched_tiles, m_mism);
      check("tries", tries, m_tries);
      check("game_won", game_won, m_won);
      check("busy", busy, exp_busy);
      check("no_overlap", matched_tiles & face_up, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
      tick();
   endtask

   task automatic sw_set(input int idx, input bit v);
      switches[idx] = v;
      tick();
   endtask

   initial begin
      for (int i = 0; i < NT; i++) tile_values[i*VW +: VW] = VW'(i >> 1);

      // 1: basic match
      switches = '0;
      do_reset();
      check("s1_busy_pick1", busy, 0);
      sw_set(0, 1);
      check("s1_face_first", face_up, 16'h0001);
      ticks(3);
      sw_set(1, 1);
      tick();
      check("s1_matched", matched_tiles, 16'h0003);
      check("s1_face_clear", face_up, 0);
      check("s1_tries", tries, 1);
      check("s1_busy", busy, 0);

      // 2: mismatch display for exactly RC cycles
      switches = '0;
      do_reset();
      sw_set(0, 1);
      sw_set(2, 1);
      tick();
      check("s2_mism_c0", mismatched_tiles, 16'h0005);
      for (int i = 1; i < RC; i++) begin
         tick();
         check("s2_mism_hold", mismatched_tiles, 16'h0005);
      end
      tick();
      check("s2_mism_clear", mismatched_tiles, 0);
      check("s2_face_clear", face_up, 0);
      check("s2_tries", tries, 1);
      check("s2_busy", busy, 0);

      // 3: simultaneous rises, lowest wins
      switches = '0;
      do_reset();
      switches[5] = 1'b1;
      switches[3] = 1'b1;
      tick();
      check("s3_lowest", face_up, 16'h0008);
      sw_set(2, 1);
      tick();
      check("s3_matched", matched_tiles, 16'h000C);

      // 4: re-raise of a matched tile is ignored
      switches = '0;
      do_reset();
      sw_set(0, 1);
      sw_set(1, 1);
      tick();
      sw_set(0, 0);
      sw_set(0, 1);
      check("s4_face", face_up, 0);
      check("s4_tries", tries, 1);
`ifdef PICK_CANCEL_EN
      sw_set(4, 1);
      check("s4_pick4", face_up, 16'h0010);
      sw_set(4, 0);
      check("s4_cancel", face_up, 0);
      check("s4_cancel_tries", tries, 1);
`endif

      // 5: full game and new_game
      switches = '0;
      do_reset();
      for (int p = 0; p < NT / 2; p++) begin
         sw_set(2 * p, 1);
         sw_set(2 * p + 1, 1);
         tick();
      end
      check("s5_all", matched_tiles, 16'hFFFF);
      check("s5_won", game_won, 1);
      check("s5_tries", tries, 8);
      tick();
      check("s5_won_hold", game_won, 1);
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check("s5_ng_matched", matched_tiles, 0);
      check("s5_ng_won", game_won, 0);
      check("s5_ng_tries", tries, 0);
      tick();
      check("s5_ng_pick1", busy, 0);
      check("s5_ng_no_pick", face_up, 0);

      // 6: switch held through reset; reset during mismatch display
      switches = '0;
      switches[7] = 1'b1;
      do_reset();
      tick();
      check("s6_held", face_up, 0);
      sw_set(0, 1);
      sw_set(2, 1);
      ticks(2);
      check("s6_in_show", mismatched_tiles, 16'h0005);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s6_rst_mism", mismatched_tiles, 0);
      check("s6_rst_face", face_up, 0);
      check("s6_rst_tries", tries, 0);
      ticks(RC + 2);

      // Random play with random tile values and occasional new_game
      switches = '0;
      tile_values = 48'({$urandom(), $urandom()});
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int k;
            k = int'($urandom_range(0, NT - 1));
            switches[k] = ~switches[k];
         end
         new_game = ($urandom_range(0, 299) == 0);
         values_valid = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) tile_values = 48'({$urandom(), $urandom()});
         tick();
      end
      new_game = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
